// File: rtl/digit_ram_arbiter_if.sv
// Read-side bundle between the digit RAM arbiter, its two requesters and the RAM read port.
// slave = arbiter view, master = requesters plus RAM view.
interface digit_ram_arbiter_if #(
  parameter int N  = 10,
  parameter int AW = 6
);
  logic          eng_req;
  logic          eng_lock;
  logic [AW-1:0] eng_addr;
  logic          eng_gnt;
  logic          eng_rvalid;
  logic [N-1:0]  eng_rdata;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [N-1:0]  disp_rdata;

  logic [AW-1:0] ram_rdadd;
  logic [N-1:0]  ram_q;

  modport slave (
    input  eng_req, eng_lock, eng_addr, disp_req, disp_addr, ram_q,
    output eng_gnt, eng_rvalid, eng_rdata, disp_gnt, disp_rvalid, disp_rdata, ram_rdadd
  );

  modport master (
    output eng_req, eng_lock, eng_addr, disp_req, disp_addr, ram_q,
    input  eng_gnt, eng_rvalid, eng_rdata, disp_gnt, disp_rvalid, disp_rdata, ram_rdadd
  );
endinterface

// File: rtl/digit_ram_arbiter.sv
// Shares one digit RAM read port between the pi engine and the display fetch; returns data RAMDELAY cycles after grant.
// No backpressure: requesters hold req until gnt; ARB_STATS_EN adds conflict_cnt / max_wait counters.
module digit_ram_arbiter #(
  parameter int N        = 10,
  parameter int AW       = 6,
  parameter int RAMDELAY = 2,
  parameter int MAXWAIT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  digit_ram_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         conflict_cnt,
  output logic [3:0]          max_wait
`endif
);

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  logic                disp_gnt;
  logic                eng_gnt;
  logic                any_gnt;
  logic [AW-1:0]       win_addr;
  logic [3:0]          starve;
  logic [3:0]          starve_nxt;
  logic [RAMDELAY-1:0] pipe_vld;
  logic [RAMDELAY-1:0] pipe_disp;
  logic [N-1:0]        rd_dat;

  // Grants are forced low during reset so nothing is issued into a pipeline being cleared.
  assign disp_gnt = rst & bus.disp_req & ~bus.eng_lock & (~bus.eng_req | (starve == MAXW));
  assign eng_gnt  = rst & bus.eng_req & ~disp_gnt;
  assign any_gnt  = eng_gnt | disp_gnt;
  assign win_addr = disp_gnt ? bus.disp_addr : bus.eng_addr;

  assign bus.eng_gnt  = eng_gnt;
  assign bus.disp_gnt = disp_gnt;

  // A lost display request keeps counting under lock, but an idle display under lock does not clear it.
  always_comb begin
    starve_nxt = starve;
    if (disp_gnt) begin
      starve_nxt = '0;
    end else if (bus.disp_req) begin
      if (starve < MAXW) starve_nxt = starve + 4'd1;
    end else if (!bus.eng_lock) begin
      starve_nxt = '0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      starve        <= '0;
      bus.ram_rdadd <= '0;
      pipe_vld      <= '0;
      pipe_disp     <= '0;
    end else begin
      starve       <= starve_nxt;
      pipe_vld[0]  <= any_gnt;
      pipe_disp[0] <= disp_gnt;
      if (any_gnt) bus.ram_rdadd <= win_addr;
      for (int i = 1; i < RAMDELAY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_disp[i] <= pipe_disp[i-1];
      end
    end
  end

  assign rd_dat          = bus.ram_q;
  assign bus.eng_rdata   = rd_dat;
  assign bus.disp_rdata  = rd_dat;
  assign bus.eng_rvalid  = pipe_vld[RAMDELAY-1] & ~pipe_disp[RAMDELAY-1];
  assign bus.disp_rvalid = pipe_vld[RAMDELAY-1] &  pipe_disp[RAMDELAY-1];

`ifdef ARB_STATS_EN
  always_ff @(negedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
      max_wait     <= '0;
    end else begin
      if (bus.eng_req && bus.disp_req && !disp_gnt && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (starve_nxt > max_wait)
        max_wait <= starve_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_digit_ram_arbiter.sv
// Directed bench for digit_ram_arbiter: per-cycle vector table plus contention, lock and mid-flight reset sequences.
module tb_digit_ram_arbiter;

  localparam int N       = 10;
  localparam int AW      = 6;
  localparam int MAXWAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  digit_ram_arbiter_if #(.N(N), .AW(AW)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [3:0]  max_wait;
`endif

  digit_ram_arbiter #(.N(N), .AW(AW), .RAMDELAY(2), .MAXWAIT(MAXWAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .max_wait     (max_wait)
`endif
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [N-1:0] ram_fn(input logic [AW-1:0] a);
    return 10'((int'(a) * 37 + 11) % 1024);
  endfunction

  // RAM output register: together with the registered address this gives two cycles of latency.
  always @(negedge clk) bus.ram_q <= ram_fn(bus.ram_rdadd);

  typedef struct {
    logic          rst;
    logic          er;
    logic          el;
    logic [AW-1:0] ea;
    logic          dr;
    logic [AW-1:0] da;
    logic          eg;
    logic          dg;
    logic          ev;
    logic          dv;
    logic [AW-1:0] dadr;
    logic [AW-1:0] rdadd;
    logic [3:0]    st;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic er, input logic el, input logic [AW-1:0] ea,
                       input logic dr, input logic [AW-1:0] da);
    rst           = r;
    bus.eng_req   = er;
    bus.eng_lock  = el;
    bus.eng_addr  = ea;
    bus.disp_req  = dr;
    bus.disp_addr = da;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    //          rst er el ea dr da  eg dg ev dv dadr rdadd st
    tv[0]  = '{1'b0, 1'b1, 1'b0, 6'd5, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 4'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 6'd5, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 4'd0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 6'd4, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd5, 4'd0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 6'd3, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 6'd4, 4'd0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 6'd3, 4'd0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 6'd3, 4'd0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd3, 4'd0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd3, 4'd0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd9, 4'd0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd9, 6'd9, 4'd0};
    tv[10] = '{1'b1, 1'b1, 1'b0, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd9, 4'd0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd1, 4'd1};
    tv[12] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 6'd2, 4'd0};
    tv[13] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 6'd2, 4'd0};
    tv[14] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 4'd0};
    tv[15] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 4'd1};
    tv[16] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 4'd2};
    tv[17] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 4'd2};
    tv[18] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 4'd2};
    tv[19] = '{1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 4'd0};

    #1;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(tv[i].rst, tv[i].er, tv[i].el, tv[i].ea, tv[i].dr, tv[i].da);
      @(posedge clk);
      chk($sformatf("eng_gnt[%0d]", i),     int'(bus.eng_gnt),     int'(tv[i].eg));
      chk($sformatf("disp_gnt[%0d]", i),    int'(bus.disp_gnt),    int'(tv[i].dg));
      chk($sformatf("eng_rvalid[%0d]", i),  int'(bus.eng_rvalid),  int'(tv[i].ev));
      chk($sformatf("disp_rvalid[%0d]", i), int'(bus.disp_rvalid), int'(tv[i].dv));
      chk($sformatf("ram_rdadd[%0d]", i),   int'(bus.ram_rdadd),   int'(tv[i].rdadd));
      chk($sformatf("starve[%0d]", i),      int'(dut.starve),      int'(tv[i].st));
      if (tv[i].ev)
        chk($sformatf("eng_rdata[%0d]", i), int'(bus.eng_rdata), int'(ram_fn(tv[i].dadr)));
      if (tv[i].dv)
        chk($sformatf("disp_rdata[%0d]", i), int'(bus.disp_rdata), int'(ram_fn(tv[i].dadr)));
      next_cycle();
    end

    // Continuous contention: engine wins four cycles, display wins the fifth.
    do_reset();
`ifdef ARB_STATS_EN
    @(posedge clk);
    chk("conflict_cnt_reset", int'(conflict_cnt), 0);
    chk("max_wait_reset", int'(max_wait), 0);
    next_cycle();
`endif
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 1'b1, 1'b0, 6'(k), 1'b1, 6'(40 + k));
      @(posedge clk);
`ifdef ARB_STATS_EN
      if (k == 10) begin
        chk("conflict_cnt_10", int'(conflict_cnt), 8);
        chk("max_wait_10", int'(max_wait), 4);
      end
`endif
      chk($sformatf("cont_disp_gnt[%0d]", k), int'(bus.disp_gnt), (k % 5 == 4) ? 1 : 0);
      chk($sformatf("cont_eng_gnt[%0d]", k),  int'(bus.eng_gnt),  (k % 5 == 4) ? 0 : 1);
      next_cycle();
    end

    // Lock: display is starved for 20 cycles, then wins the first unlocked cycle.
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 1'b1, 6'd11, 1'b1, 6'd22);
      @(posedge clk);
      chk($sformatf("lock_disp_gnt[%0d]", k), int'(bus.disp_gnt), 0);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 6'd11, 1'b1, 6'd22);
    @(posedge clk);
    chk("unlock_starve", int'(dut.starve), MAXWAIT);
    chk("unlock_disp_gnt", int'(bus.disp_gnt), 1);
    chk("unlock_eng_gnt", int'(bus.eng_gnt), 0);
    next_cycle();

    // Reset one edge after an engine grant must drop that read.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) next_cycle();
    drive(1'b1, 1'b1, 1'b0, 6'd7, 1'b0, '0);
    @(posedge clk);
    chk("mid_eng_gnt", int'(bus.eng_gnt), 1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    @(posedge clk);
    chk("mid_rdadd_issued", int'(bus.ram_rdadd), 7);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    @(posedge clk);
    chk("post_rst_rdadd", int'(bus.ram_rdadd), 0);
    chk("post_rst_starve", int'(dut.starve), 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(posedge clk);
      chk($sformatf("post_rst_eng_rvalid[%0d]", k),  int'(bus.eng_rvalid), 0);
      chk($sformatf("post_rst_disp_rvalid[%0d]", k), int'(bus.disp_rvalid), 0);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_ram_arbiter.md
Name: digit_ram_arbiter

Overview:
- Shares the single read port of one multi-word digit RAM (two-port, fixed read latency) between two requesters.
- Requester 1 is the pi compute engine (sweeps words for add/sub/div phases). Requester 2 is the display fetch unit (pulls words for the VGA digit renderer).
- Performs priority arbitration, bounds display starvation, tracks in-flight reads through the RAM latency, and routes returned data to the owner with a valid strobe.

Parameters:
- N, 10, RAM word width (one digit group).
- AW, 6, RAM address width.
- RAMDELAY, 2, cycles from address registered to ram_q valid; legal range 1..4.
- MAXWAIT, 4, consecutive lost cycles before the display is force-granted; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on falling edge, matching the compute controller.
- rst  in  1  reset, synchronous, active-low.
- eng_req  in  1  engine read request; held until granted.
- eng_lock  in  1  engine burst lock; while high, display is never granted.
- eng_addr  in  AW  engine read address.
- eng_gnt  out  1  engine request accepted this cycle.
- eng_rvalid  out  1  eng_rdata valid.
- eng_rdata  out  N  read data for engine.
- disp_req  in  1  display read request; held until granted.
- disp_addr  in  AW  display read address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  disp_rdata valid.
- disp_rdata  out  N  read data for display.
- ram_rdadd  out  AW  RAM read address (registered).
- ram_q  in  N  RAM read data.

Behaviour:
- Grant (combinational, per cycle):
  - disp_gnt = disp_req & !eng_lock & (!eng_req | starve == MAXWAIT).
  - eng_gnt = eng_req & !disp_gnt.
  - At most one grant per cycle. Both grants are 0 while rst = 0.
- Starvation counter starve (4 bit), updated each falling edge:
  - Increments when disp_req & !disp_gnt, saturating at MAXWAIT.
  - Clears to 0 on disp_gnt or when disp_req = 0.
  - Holds its value (no clear) while eng_lock = 1.
- Address issue: on the falling edge ending a granted cycle, ram_rdadd <= winner's address. With no grant, ram_rdadd holds its previous value.
- Latency pipeline:
  - RAMDELAY-deep shift register of {valid, owner}. Stage 0 loads {1, winner} on a grant, {0, x} otherwise.
  - The last stage drives eng_rvalid or disp_rvalid for exactly one cycle, RAMDELAY cycles after the grant cycle.
  - eng_rdata and disp_rdata both = ram_q. Data is meaningful only with the matching rvalid.
- Back-to-back grants are legal every cycle. Returns stay in grant order with no reordering.
- Simultaneous requests: engine wins unless the starvation override applies; the lock always wins.
- Lock release: starve is already saturated, so a pending display request is granted on the first cycle after eng_lock falls, even if eng_req is still high.
- Reset (rst = 0 at a falling edge):
  - ram_rdadd = 0, starve = 0, all pipeline valids = 0.
  - eng_rvalid = disp_rvalid = 0.
  - In-flight reads at reset are discarded and never produce rvalid.
- Address width: address is passed through unchanged, with no bounds check. The requester guarantees address < L.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds output port conflict_cnt, 16 bit.
  - Increments on each falling edge where eng_req & disp_req are both high and the display is not granted. Saturates at 16'hFFFF; cleared by reset.
  - Adds output port max_wait, 4 bit: the highest starve value reached since reset.
- Not defined: both ports and their logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Engine only, RAMDELAY = 2: eng_req with addr 5,4,3 on consecutive cycles -> eng_gnt high 3 cycles; ram_rdadd 5,4,3; eng_rvalid high on cycles 2,3,4 after first grant with RAM contents of 5,4,3; disp_rvalid stays 0.
- Display only: disp_req addr 9 -> disp_gnt same cycle; ram_rdadd = 9 next edge; disp_rvalid one cycle, 2 cycles later, data = RAM[9].
- Contention, MAXWAIT = 4, no lock, both requesting continuously -> engine granted 4 cycles, display granted on 5th, starve back to 0, pattern repeats (4:1).
- eng_lock = 1 for 20 cycles with both requesting -> 0 display grants, starve = 4; lock drops -> disp_gnt in the first unlocked cycle.
- Reset mid-flight: grant engine addr 7, assert rst = 0 on the next falling edge -> no eng_rvalid ever for addr 7; after release, ram_rdadd = 0 and starve = 0.
- ARB_STATS_EN: run the contention case for 10 cycles -> conflict_cnt = 8, max_wait = 4.
